fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_counter.sv | 29 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction-word field positions and the
// fetch state encoding.
package cpu_pkg;

  localparam int IR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [3:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: reset value, load for redirects, increment with natural
// wrap at 2^PC_W. Load takes priority over increment.
module pc_counter #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at the PC, holds it in the IR until
// decode accepts it, and parks in HALTED after a consumed HALT.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_REQ    | imem_req high at pc, waiting for imem_ack
// S_HOLD   | IR valid toward decode, waiting for instr_ready
// S_HALTED | HALT consumed; fetch stopped until a redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            halted
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [IR_W-1:0] r_ir;
  logic            w_ir_load;
  logic            w_pc_inc;
  logic [PC_W-1:0] w_pc;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (redirect),
    .i_load_pc (redirect_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= imem_rdata;
    end
  end

  // Redirect overrides every state; data arriving with it is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_inc    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_state_nxt = S_REQ;
        end else if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_state_nxt = S_REQ;
        end else if (instr_ready) begin
          w_state_nxt = is_halt(r_ir[OPC_HI:OPC_LO]) ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: begin
        if (redirect) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // Gating with rst_n keeps the request low for the whole reset interval.
  assign imem_req    = (r_state == S_REQ) && rst_n;
  assign imem_addr   = w_pc;
  assign instr_valid = (r_state == S_HOLD);
  assign halted      = (r_state == S_HALTED);
  assign opcode      = r_ir[OPC_HI:OPC_LO];
  assign rd          = r_ir[RD_HI:RD_LO];
  assign rs1         = r_ir[RS1_HI:RS1_LO];
  assign rs2         = r_ir[RS2_HI:RS2_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed fetch scenarios followed by a randomized run against a
// behavioural model of the fetch/hold/halt protocol.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_W(8), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ir_out();
    return {opcode, rd, rs1, rs2};
  endfunction

  // behavioural model state
  int          m_pc;
  logic [15:0] m_ir;
  bit          m_have;
  bit          m_halt;

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b0;
    tick();
    tick();

    chk("rst_req",   imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halt",  halted, 0);
    chk("rst_ir",    ir_out(), 16'h0000);
    chk("rst_addr",  imem_addr, 8'h00);

    rst_n = 1'b1;
    #1;
    chk("first_req",  imem_req, 1);
    chk("first_addr", imem_addr, 8'h00);

    // zero-wait fetch of 1123
    imem_ack = 1'b1; imem_rdata = 16'h1123; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("t1_ir",    ir_out(), 16'h1123);
    chk("t1_valid", instr_valid, 1);
    chk("t1_req",   imem_req, 0);
    chk("t1_addr",  imem_addr, 8'h01);
    tick();
    chk("t1_valid_drop", instr_valid, 0);
    chk("t1_req_next",   imem_req, 1);
    chk("t1_addr_next",  imem_addr, 8'h01);

    // delayed ack, then stalled decode
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_addr", imem_addr, 8'h01);
      chk("t2_wait_req",  imem_req, 1);
      chk("t2_wait_valid", instr_valid, 0);
    end
    imem_ack = 1'b1; imem_rdata = 16'h2456;
    tick();
    imem_ack = 1'b0; imem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_ir",    ir_out(), 16'h2456);
      chk("t2_hold_valid", instr_valid, 1);
      chk("t2_hold_req",   imem_req, 0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
    end
    chk("t2_hold_ir_end", ir_out(), 16'h2456);
    instr_ready = 1'b1;
    tick();
    chk("t2_addr_next", imem_addr, 8'h02);
    chk("t2_req_next",  imem_req, 1);

    // wrap from FF
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    chk("t3_addr_ff", imem_addr, 8'hFF);
    imem_ack = 1'b1; imem_rdata = 16'h3789;
    tick();
    imem_ack = 1'b0;
    chk("t3_wrap_addr", imem_addr, 8'h00);
    chk("t3_ir",        ir_out(), 16'h3789);
    tick();
    chk("t3_req", imem_req, 1);

    // redirect coincident with ack
    imem_ack = 1'b1; imem_rdata = 16'h4ABC; redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    chk("t4_ir_kept", ir_out(), 16'h3789);
    chk("t4_addr",    imem_addr, 8'h40);
    chk("t4_valid",   instr_valid, 0);
    chk("t4_req",     imem_req, 1);

    // redirect beats HALT at handshake
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    tick();
    imem_ack = 1'b0;
    chk("t5_addr", imem_addr, 8'h41);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    chk("t5_halted", halted, 0);
    chk("t5_addr_r", imem_addr, 8'h20);
    chk("t5_req",    imem_req, 1);

    // HALT consumed
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("t6_halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("t6_req_idle", imem_req, 0);
      chk("t6_halt_hold", halted, 1);
      chk("t6_valid", instr_valid, 0);
    end
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    chk("t6_unhalt", halted, 0);
    chk("t6_addr",   imem_addr, 8'h10);
    chk("t6_req",    imem_req, 1);

    // reset during HOLD
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    chk("t7_valid_pre", instr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_valid_rst", instr_valid, 0);
    chk("t7_req_rst",   imem_req, 0);
    chk("t7_ir_rst",    ir_out(), 16'h0000);
    tick();
    chk("t7_req_in_rst", imem_req, 0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("t7_addr_rel", imem_addr, 8'h00);
    chk("t7_req_rel",  imem_req, 1);
    tick();
    chk("t7_addr_hold", imem_addr, 8'h00);
    chk("t7_valid_rel", instr_valid, 0);

    // randomized run
    m_pc = 0; m_ir = 16'h0000; m_have = 0; m_halt = 0;
    for (int n = 0; n < 400; n++) begin
      chk("rnd_req",   imem_req, 32'(!m_have && !m_halt));
      chk("rnd_addr",  imem_addr, 32'(m_pc));
      chk("rnd_valid", instr_valid, 32'(m_have));
      chk("rnd_halt",  halted, 32'(m_halt));
      chk("rnd_ir",    ir_out(), 32'(m_ir));

      imem_ack    = ($urandom_range(0, 2) != 0);
      imem_rdata  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 5) == 0) imem_rdata[15:12] = 4'hF;
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = 8'($urandom_range(0, 255));

      if (redirect) begin
        m_pc = int'(redirect_pc); m_have = 0; m_halt = 0;
      end else if (m_halt) begin
        m_halt = 1;
      end else if (m_have) begin
        if (instr_ready) begin
          m_have = 0;
          if (m_ir[15:12] == 4'hF) m_halt = 1;
        end
      end else if (imem_ack) begin
        m_ir = imem_rdata;
        m_pc = (m_pc + 1) % 256;
        m_have = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
